// File: rtl/max_pool.sv
// max_pool: 2x2, stride-2 max-pooling stage.
//
// Reads the feature-map geometry (depth, height, width) from the parameter
// area, then streams the input map out of DRAM one word per cycle (fixed
// 1-cycle read latency) and writes one pooled pixel per 4 cycles to the output
// region. An odd last row/column is dropped; a zero-sized map completes without
// touching the maps.
//
// Ports:
//   clk        in   clock
//   srstn      in   synchronous active-low reset
//   enable     in   start request, sampled only while idle
//   data_in    in   DRAM read data, valid the cycle after the read address
//   data_out   out  write data (0 when dram_en_wr is low)
//   addr_in    out  read address (0 when dram_en_rd is low)
//   addr_out   out  write address (0 when dram_en_wr is low)
//   dram_en_rd out  read strobe
//   dram_en_wr out  write strobe
//   done       out  one-cycle completion pulse
module max_pool #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_WIDTH    = 18,
  parameter logic [ADDR_WIDTH-1:0] PARAM_BASE    = 18'd0,
  parameter logic [ADDR_WIDTH-1:0] FMAP_IN_BASE  = 18'd131072,
  parameter logic [ADDR_WIDTH-1:0] FMAP_OUT_BASE = 18'd196608
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  done
);

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    LD_PARAM = 5'b00010,
    POOL     = 5'b00100,
    DRAIN    = 5'b01000,
    DONE     = 5'b10000
  } state_t;

  state_t state_q, state_d;

  // Geometry: depth in 1..16, pooled height/width (odd last row/col dropped).
  logic [4:0] depth_q, depth_d;
  logic [3:0] oh_q, oh_d;
  logic [3:0] ow_q, ow_d;

  logic [1:0] ld_cnt_q, ld_cnt_d;

  // Position of the read issued in the current cycle.
  logic [3:0] d_q, d_d;
  logic [3:0] ro_q, ro_d;
  logic [3:0] co_q, co_d;
  logic [1:0] k_q, k_d;

  // Tags for the datum arriving on data_in this cycle.
  logic       pend_vld_q, pend_vld_d;
  logic [1:0] pend_k_q, pend_k_d;

  logic signed [DATA_WIDTH-1:0] acc_q, acc_d;

  logic                  rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] addr_in_q, addr_in_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_out_q, addr_out_d;
  logic                  done_q, done_d;

  logic signed [DATA_WIDTH-1:0] max_val;
  logic last_k, last_co, last_ro, last_d;

  // Input pixel (d, 2ro+k[1], 2co+k[0]) in {d[3:0], r[4:0], c[4:0]} packing.
  function automatic logic [ADDR_WIDTH-1:0] in_addr(input logic [3:0] d,
                                                    input logic [3:0] ro,
                                                    input logic [3:0] co,
                                                    input logic [1:0] k);
    return FMAP_IN_BASE + ADDR_WIDTH'({d, ro, k[1], co, k[0]});
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] out_addr(input logic [3:0] d,
                                                     input logic [3:0] ro,
                                                     input logic [3:0] co);
    return FMAP_OUT_BASE + ADDR_WIDTH'({d, 1'b0, ro, 1'b0, co});
  endfunction

  assign max_val = ($signed(data_in) > acc_q) ? $signed(data_in) : acc_q;

  assign last_k  = (k_q == 2'd3);
  assign last_co = (co_q == ow_q - 4'd1);
  assign last_ro = (ro_q == oh_q - 4'd1);
  assign last_d  = ({1'b0, d_q} == depth_q - 5'd1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; without this the tool would infer latches.
    state_d    = state_q;
    depth_d    = depth_q;
    oh_d       = oh_q;
    ow_d       = ow_q;
    ld_cnt_d   = ld_cnt_q;
    d_d        = d_q;
    ro_d       = ro_q;
    co_d       = co_q;
    k_d        = k_q;
    pend_vld_d = 1'b0;
    pend_k_d   = k_q;
    acc_d      = acc_q;
    rd_d       = 1'b0;
    addr_in_d  = '0;
    wr_d       = 1'b0;
    addr_out_d = '0;
    done_d     = 1'b0;

    // The k=0 datum restarts the window; later data keep the running max.
    if (pend_vld_q) begin
      acc_d = (pend_k_q == 2'd0) ? $signed(data_in) : max_val;
    end

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = LD_PARAM;
          ld_cnt_d  = 2'd0;
          rd_d      = 1'b1;
          addr_in_d = PARAM_BASE;
        end
      end

      LD_PARAM: begin
        ld_cnt_d = ld_cnt_q + 2'd1;
        if (ld_cnt_q < 2'd2) begin
          rd_d      = 1'b1;
          addr_in_d = PARAM_BASE + ADDR_WIDTH'(ld_cnt_q) + ADDR_WIDTH'(1);
        end
        if (ld_cnt_q == 2'd1) depth_d = data_in[4:0];
        if (ld_cnt_q == 2'd2) oh_d    = data_in[4:1];
        if (ld_cnt_q == 2'd3) begin
          ow_d = data_in[4:1];
          d_d  = '0;
          ro_d = '0;
          co_d = '0;
          k_d  = '0;
          // Width arrives this cycle, so the bypass test uses it directly.
          if (depth_q == 5'd0 || oh_q == 4'd0 || data_in[4:1] == 4'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = POOL;
            rd_d      = 1'b1;
            addr_in_d = in_addr(4'd0, 4'd0, 4'd0, 2'd0);
          end
        end
      end

      POOL: begin
        pend_vld_d = 1'b1;
        pend_k_d   = k_q;
        // The k=3 datum lands next cycle, which is when its window is written.
        if (last_k) begin
          wr_d       = 1'b1;
          addr_out_d = out_addr(d_q, ro_q, co_q);
        end
        if (last_k && last_co && last_ro && last_d) begin
          state_d = DRAIN;
          d_d     = '0;
          ro_d    = '0;
          co_d    = '0;
          k_d     = '0;
        end else begin
          k_d = k_q + 2'd1;
          if (last_k) begin
            co_d = last_co ? 4'd0 : co_q + 4'd1;
            if (last_co) begin
              ro_d = last_ro ? 4'd0 : ro_q + 4'd1;
              if (last_ro) d_d = d_q + 4'd1;
            end
          end
          rd_d      = 1'b1;
          addr_in_d = in_addr(d_d, ro_d, co_d, k_d);
        end
      end

      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!srstn) begin
      state_q    <= IDLE;
      depth_q    <= '0;
      oh_q       <= '0;
      ow_q       <= '0;
      ld_cnt_q   <= '0;
      d_q        <= '0;
      ro_q       <= '0;
      co_q       <= '0;
      k_q        <= '0;
      pend_vld_q <= 1'b0;
      pend_k_q   <= '0;
      acc_q      <= '0;
      rd_q       <= 1'b0;
      addr_in_q  <= '0;
      wr_q       <= 1'b0;
      addr_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      oh_q       <= oh_d;
      ow_q       <= ow_d;
      ld_cnt_q   <= ld_cnt_d;
      d_q        <= d_d;
      ro_q       <= ro_d;
      co_q       <= co_d;
      k_q        <= k_d;
      pend_vld_q <= pend_vld_d;
      pend_k_q   <= pend_k_d;
      acc_q      <= acc_d;
      rd_q       <= rd_d;
      addr_in_q  <= addr_in_d;
      wr_q       <= wr_d;
      addr_out_q <= addr_out_d;
      done_q     <= done_d;
    end
  end

  assign dram_en_rd = rd_q;
  assign addr_in    = addr_in_q;
  assign dram_en_wr = wr_q;
  assign addr_out   = addr_out_q;
  assign done       = done_q;
  // Final compare is combinational so the write lands with the k=3 datum.
  assign data_out   = wr_q ? max_val : '0;

endmodule

// File: tb/tb_max_pool.sv
// tb_max_pool: self-checking bench for max_pool. A DRAM model answers reads
// one cycle late; a monitor logs every read, write and done pulse with its
// cycle number; each scenario compares the logs against a pooled map and
// schedule computed directly from the feature-map contents.
module tb_max_pool;

  localparam int PARAM_BASE    = 0;
  localparam int FMAP_IN_BASE  = 131072;
  localparam int FMAP_OUT_BASE = 196608;

  logic        clk = 1'b0;
  logic        srstn;
  logic        enable;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [17:0] addr_in;
  logic [17:0] addr_out;
  logic        dram_en_rd;
  logic        dram_en_wr;
  logic        done;

  max_pool dut (
    .clk        (clk),
    .srstn      (srstn),
    .enable     (enable),
    .data_in    (data_in),
    .data_out   (data_out),
    .addr_in    (addr_in),
    .addr_out   (addr_out),
    .dram_en_rd (dram_en_rd),
    .dram_en_wr (dram_en_wr),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DRAM: fixed 1-cycle read latency.
  logic [31:0] mem [int];
  always @(posedge clk)
    data_in <= (dram_en_rd && mem.exists(int'(addr_in))) ? mem[int'(addr_in)] : 32'd0;

  int n_cmp = 0;
  int n_err = 0;

  int          rd_addr_q[$];
  int          rd_cyc_q[$];
  int          wr_addr_q[$];
  int          wr_cyc_q[$];
  logic [31:0] wr_data_q[$];
  int          done_cyc_q[$];

  always @(negedge clk) begin
    n_cmp++;
    if ((!dram_en_wr && (data_out !== 32'd0 || addr_out !== 18'd0)) ||
        (!dram_en_rd && addr_in !== 18'd0)) begin
      n_err++;
      $display("FAIL idle_outputs cyc=%0d got rd=%0b addr_in=%0d wr=%0b addr_out=%0d data_out=%0d expected zero buses",
               cyc, dram_en_rd, addr_in, dram_en_wr, addr_out, data_out);
    end
    if (dram_en_rd) begin rd_addr_q.push_back(int'(addr_in)); rd_cyc_q.push_back(cyc); end
    if (dram_en_wr) begin
      wr_addr_q.push_back(int'(addr_out));
      wr_data_q.push_back(data_out);
      wr_cyc_q.push_back(cyc);
    end
    if (done) done_cyc_q.push_back(cyc);
  end

  function automatic int in_addr(int d, int r, int c);
    return FMAP_IN_BASE + d * 1024 + r * 32 + c;
  endfunction

  task automatic clear_logs();
    rd_addr_q.delete(); rd_cyc_q.delete();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic fill_random(int dep, int h, int w);
    mem.delete();
    for (int d = 0; d < dep; d++)
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++)
          mem[in_addr(d, r, c)] = $urandom;
  endtask

  // Runs one job on the current mem contents and compares every read, write
  // and the done pulse (contents and cycle) against the pooling rules.
  task automatic run_job(string name, int dep, int h, int w);
    int exp_rd_a[$];
    int exp_rd_c[$];
    int exp_wr_a[$];
    logic [31:0] exp_wr_d[$];
    int exp_wr_c[$];
    int oh, ow, n, t0, exp_done, win, best, v;
    bit active;
    mem[PARAM_BASE + 0] = dep;
    mem[PARAM_BASE + 1] = h;
    mem[PARAM_BASE + 2] = w;
    oh = h / 2;
    ow = w / 2;
    active = (dep > 0) && (oh > 0) && (ow > 0);
    n = active ? dep * oh * ow * 4 : 0;

    @(negedge clk);
    clear_logs();
    enable = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      exp_rd_a.push_back(PARAM_BASE + i);
      exp_rd_c.push_back(t0 + 1 + i);
    end
    win = 0;
    if (active) begin
      for (int d = 0; d < dep; d++)
        for (int ro = 0; ro < oh; ro++)
          for (int co = 0; co < ow; co++) begin
            for (int k = 0; k < 4; k++) begin
              exp_rd_a.push_back(in_addr(d, 2 * ro + k / 2, 2 * co + k % 2));
              exp_rd_c.push_back(t0 + 5 + win * 4 + k);
              v = int'(mem[in_addr(d, 2 * ro + k / 2, 2 * co + k % 2)]);
              if (k == 0 || v > best) best = v;
            end
            exp_wr_a.push_back(FMAP_OUT_BASE + d * 1024 + ro * 32 + co);
            exp_wr_d.push_back(32'(best));
            exp_wr_c.push_back(t0 + 9 + win * 4);
            win++;
          end
    end
    exp_done = active ? t0 + 6 + n : t0 + 5;

    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 5000 && done_cyc_q.size() == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);

    n_cmp++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != exp_done) begin
      n_err++;
      $display("FAIL %s done_timing got %0d pulses first at %0d expected 1 pulse at %0d",
               name, done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] - t0 : -1,
               exp_done - t0);
    end
    n_cmp++;
    if (rd_addr_q.size() != exp_rd_a.size()) begin
      n_err++;
      $display("FAIL %s read_count got %0d expected %0d", name, rd_addr_q.size(), exp_rd_a.size());
    end else begin
      for (int i = 0; i < exp_rd_a.size(); i++) begin
        n_cmp++;
        if (rd_addr_q[i] != exp_rd_a[i] || rd_cyc_q[i] != exp_rd_c[i]) begin
          n_err++;
          $display("FAIL %s read[%0d] got addr=%0d at T+%0d expected addr=%0d at T+%0d",
                   name, i, rd_addr_q[i], rd_cyc_q[i] - t0, exp_rd_a[i], exp_rd_c[i] - t0);
        end
      end
    end
    n_cmp++;
    if (wr_addr_q.size() != exp_wr_a.size()) begin
      n_err++;
      $display("FAIL %s write_count got %0d expected %0d", name, wr_addr_q.size(), exp_wr_a.size());
    end else begin
      for (int i = 0; i < exp_wr_a.size(); i++) begin
        n_cmp++;
        if (wr_addr_q[i] != exp_wr_a[i] || wr_data_q[i] !== exp_wr_d[i] || wr_cyc_q[i] != exp_wr_c[i]) begin
          n_err++;
          $display("FAIL %s write[%0d] got addr=%0d data=%0d at T+%0d expected addr=%0d data=%0d at T+%0d",
                   name, i, wr_addr_q[i], $signed(wr_data_q[i]), wr_cyc_q[i] - t0,
                   exp_wr_a[i], $signed(exp_wr_d[i]), exp_wr_c[i] - t0);
        end
      end
    end
  endtask

  task automatic test_reset();
    srstn  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (dram_en_rd !== 1'b0) begin n_err++; $display("FAIL reset_rd got %0b expected 0", dram_en_rd); end
    n_cmp++; if (dram_en_wr !== 1'b0) begin n_err++; $display("FAIL reset_wr got %0b expected 0", dram_en_wr); end
    n_cmp++; if (addr_in !== 18'd0) begin n_err++; $display("FAIL reset_addr_in got %0d expected 0", addr_in); end
    n_cmp++; if (addr_out !== 18'd0) begin n_err++; $display("FAIL reset_addr_out got %0d expected 0", addr_out); end
    n_cmp++; if (data_out !== 32'd0) begin n_err++; $display("FAIL reset_data_out got %0d expected 0", data_out); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b expected 0", done); end
    srstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_4x4();
    int ea[4] = '{196608, 196609, 196640, 196641};
    int ed[4] = '{5, 7, 13, 15};
    mem.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        mem[in_addr(0, r, c)] = 32'(r * 4 + c);
    run_job("basic_4x4", 1, 4, 4);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (wr_addr_q.size() != 4 || wr_addr_q[i] != ea[i] || wr_data_q[i] !== 32'(ed[i])) begin
        n_err++;
        $display("FAIL basic_4x4_const[%0d] got %0d writes expected addr=%0d data=%0d",
                 i, wr_addr_q.size(), ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_signed_2x2x2();
    int vals[8] = '{3, -2, 7, 1, -5, -1, -9, -3};
    mem.delete();
    for (int i = 0; i < 8; i++) mem[in_addr(i / 4, (i / 2) % 2, i % 2)] = 32'(vals[i]);
    run_job("signed_2x2x2", 2, 2, 2);
    n_cmp++;
    if (wr_addr_q.size() != 2 || wr_addr_q[1] != 197632 || wr_data_q[1] !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL signed_all_negative got %0d writes expected 197632=-1 last", wr_addr_q.size());
    end
  endtask

  task automatic test_odd_3x5();
    fill_random(1, 3, 5);
    run_job("odd_3x5", 1, 3, 5);
    for (int i = 0; i < rd_addr_q.size(); i++) begin
      if (rd_addr_q[i] >= FMAP_IN_BASE) begin
        n_cmp++;
        if (((rd_addr_q[i] >> 5) & 31) == 2 || (rd_addr_q[i] & 31) == 4) begin
          n_err++;
          $display("FAIL odd_dropped_pixel got read addr=%0d expected row<2 col<4", rd_addr_q[i]);
        end
      end
    end
  endtask

  task automatic test_bypass();
    mem.delete();
    run_job("bypass_w1", 1, 4, 1);
    mem.delete();
    run_job("bypass_d0", 0, 4, 4);
    fill_random(1, 4, 4);
    run_job("restart_after_bypass", 1, 4, 4);
  endtask

  task automatic test_depth16();
    fill_random(16, 2, 2);
    run_job("depth16", 16, 2, 2);
    n_cmp++;
    if (wr_addr_q.size() != 16 || wr_addr_q[15] != FMAP_OUT_BASE + 15 * 1024) begin
      n_err++;
      $display("FAIL depth16_last_addr got %0d writes expected last addr=%0d",
               wr_addr_q.size(), FMAP_OUT_BASE + 15 * 1024);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      int dep, h, w;
      dep = $urandom_range(1, 3);
      h   = $urandom_range(1, 7);
      w   = $urandom_range(1, 7);
      fill_random(dep, h, w);
      run_job($sformatf("random%0d_%0dx%0dx%0d", i, dep, h, w), dep, h, w);
    end
  endtask

  task automatic test_reset_mid_pool();
    int t0;
    fill_random(1, 4, 4);
    mem[PARAM_BASE + 0] = 1;
    mem[PARAM_BASE + 1] = 4;
    mem[PARAM_BASE + 2] = 4;
    @(negedge clk);
    clear_logs();
    enable = 1'b1;
    t0 = cyc;
    repeat (11) @(negedge clk);   // now in POOL index 6 (cycle T+11)
    srstn  = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    n_cmp++;
    if (dram_en_rd !== 1'b0 || dram_en_wr !== 1'b0 || addr_in !== 18'd0 ||
        addr_out !== 18'd0 || data_out !== 32'd0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_outputs got rd=%0b wr=%0b addr_in=%0d addr_out=%0d data_out=%0d done=%0b expected all 0",
               dram_en_rd, dram_en_wr, addr_in, addr_out, data_out, done);
    end
    srstn = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] != FMAP_OUT_BASE) begin
      n_err++;
      $display("FAIL midreset_writes got %0d writes expected only window 0", wr_addr_q.size());
    end
    n_cmp++;
    if (done_cyc_q.size() != 0 || rd_cyc_q.size() == 0 || rd_cyc_q[rd_cyc_q.size() - 1] > t0 + 11) begin
      n_err++;
      $display("FAIL midreset_quiet got %0d done pulses, %0d reads expected no activity after T+11",
               done_cyc_q.size(), rd_cyc_q.size());
    end
    fill_random(2, 4, 2);
    run_job("restart_after_reset", 2, 4, 2);
  endtask

  initial begin
    test_reset();
    test_basic_4x4();
    test_signed_2x2x2();
    test_odd_3x5();
    test_bypass();
    test_depth16();
    test_random();
    test_reset_mid_pool();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
